// File: rtl/snn_mon_pkg.sv
// Shared types and constants for the tinySNN spike response monitor.
// Holds the result record layout, the FSM state encoding and the winner-decode helper.
package snn_mon_pkg;

  localparam int P_NEURONS    = 8;
  localparam int P_INPUTS     = 42;
  localparam int IDX_W        = 4;
  localparam int SAMPLE_IDX_W = 16;
  localparam int EPOCH_W      = 8;
  localparam int P_CNT_W      = 4;
  localparam int TOTAL_W      = P_CNT_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_CLOSE
  } mon_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]        winner;
    logic [P_CNT_W-1:0]      win_count;
    logic [TOTAL_W-1:0]      total_count;
    logic [SAMPLE_IDX_W-1:0] sample_index;
    logic [EPOCH_W-1:0]      epoch;
  } result_t;

  // 1-based index of the lowest spiking neuron, 0 when none spiked.
  function automatic logic [IDX_W-1:0] first_spiker(input logic [P_NEURONS-1:0] spikes);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int n = P_NEURONS - 1; n >= 0; n--) begin
      if (spikes[n]) idx = IDX_W'(n + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spike_result_fifo.sv
// Small synchronous FIFO for result records; a push into a full FIFO succeeds
// only when a pop happens in the same cycle. Head data reads as zero while empty.
module spike_result_fifo #(
  parameter int p_width = 8,
  parameter int p_depth = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [p_width-1:0] i_data,
  input  logic               i_pop,
  output logic [p_width-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_width-1:0] mem_reg [p_depth];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               do_push;
  logic               do_pop;

  assign o_full  = (count_reg == (PTR_W + 1)'(p_depth));
  assign o_empty = (count_reg == '0);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_data  = o_empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= i_data;
  end

endmodule

// File: rtl/spike_response_monitor.sv
// Frames stimulus sample slots, scores the output-neuron spikes in a short response
// window and queues one result record per sample for a valid/ready consumer.
module spike_response_monitor
  import snn_mon_pkg::*;
#(
  parameter int p_window     = 5,
  parameter int p_epoch_gap  = 50,
  parameter int p_fifo_depth = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P_INPUTS:1]       i_test_vector,
  input  logic [P_NEURONS:1]      i_spikes,
  input  logic                    i_end_of_epochs,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [IDX_W-1:0]        o_winner,
  output logic [P_CNT_W-1:0]      o_win_count,
  output logic [TOTAL_W-1:0]      o_total_count,
  output logic [SAMPLE_IDX_W-1:0] o_sample_index,
  output logic [EPOCH_W-1:0]      o_epoch,
  output logic                    o_epoch_done,
  output logic                    o_overflow
);

  localparam int WIN_W = (p_window > 1) ? $clog2(p_window) : 1;
  localparam int GAP_W = $clog2(p_epoch_gap + 1);
  localparam int SEL_W = $clog2(P_NEURONS);
  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0]   GAP_MAX = GAP_W'(p_epoch_gap);

  mon_state_t                        state_reg, state_next;
  logic [WIN_W-1:0]                  win_cnt_reg;
  logic [P_NEURONS-1:0][P_CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0]                  winner_reg, winner_next;
  logic [TOTAL_W-1:0]                total_reg, total_next;
  logic [SAMPLE_IDX_W-1:0]           sample_idx_reg, win_idx_reg;
  logic [EPOCH_W-1:0]                epoch_reg, win_epoch_reg;
  logic [GAP_W-1:0]                  gap_reg;
  logic                              seen_sample_reg, eoe_prev_reg, epoch_done_reg;
  logic                              overflow_reg, push_reg;
  result_t                           rec_reg, rec_next, head;
  logic [SEL_W-1:0]                  win_sel;
  logic [P_NEURONS-1:0]              spikes;
  logic pulse, open_win, close_win, last_cycle, eoe_rise, gap_boundary;
  logic fifo_full, fifo_empty, pop;

  assign spikes       = i_spikes;
  assign pulse        = |i_test_vector;
  assign last_cycle   = (win_cnt_reg == WIN_W'(p_window - 1));
  assign eoe_rise     = i_end_of_epochs && !eoe_prev_reg;
  assign gap_boundary = (state_reg == ST_IDLE) && !pulse && seen_sample_reg &&
                        (gap_reg == GAP_W'(p_epoch_gap - 1));

  genvar gi;
  generate
    for (gi = 0; gi < P_NEURONS; gi++) begin : g_neuron
      logic [P_CNT_W-1:0] cnt_reg;
      assign cnt_next[gi] = (spikes[gi] && cnt_reg != CNT_MAX) ? cnt_reg + 1'b1 : cnt_reg;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  cnt_reg <= '0;
        else if (open_win)             cnt_reg <= '0;
        else if (state_reg == ST_WINDOW) cnt_reg <= cnt_next[gi];
      end
    end
  endgenerate

  always_comb begin
    logic [TOTAL_W:0] sum;
    sum = {1'b0, total_reg};
    for (int n = 0; n < P_NEURONS; n++) sum = sum + (TOTAL_W + 1)'(spikes[n]);
    total_next = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
  end

  // The record is built from this cycle's spikes too, so an early close loses nothing.
  assign winner_next = (winner_reg == '0) ? first_spiker(spikes) : winner_reg;
  assign win_sel     = SEL_W'(winner_next - 1'b1);

  always_comb begin
    rec_next              = '0;
    rec_next.winner       = winner_next;
    rec_next.win_count    = (winner_next == '0) ? '0 : cnt_next[win_sel];
    rec_next.total_count  = total_next;
    rec_next.sample_index = win_idx_reg;
    rec_next.epoch        = win_epoch_reg;
  end

  always_comb begin
    state_next = state_reg;
    open_win   = 1'b0;
    close_win  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pulse) begin
          open_win   = 1'b1;
          state_next = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (pulse) begin
          close_win  = 1'b1;
          open_win   = 1'b1;
          state_next = ST_WINDOW;
        end else if (last_cycle) begin
          close_win  = 1'b1;
          state_next = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        state_next = ST_IDLE;
        if (pulse) begin
          open_win   = 1'b1;
          state_next = ST_WINDOW;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= ST_IDLE;
      win_cnt_reg     <= '0;
      winner_reg      <= '0;
      total_reg       <= '0;
      sample_idx_reg  <= '0;
      win_idx_reg     <= '0;
      epoch_reg       <= '0;
      win_epoch_reg   <= '0;
      gap_reg         <= '0;
      seen_sample_reg <= 1'b0;
      eoe_prev_reg    <= 1'b0;
      epoch_done_reg  <= 1'b0;
      overflow_reg    <= 1'b0;
      push_reg        <= 1'b0;
      rec_reg         <= '0;
    end else begin
      state_reg    <= state_next;
      push_reg     <= close_win;
      eoe_prev_reg <= i_end_of_epochs;
      epoch_done_reg <= eoe_rise;
      if (close_win) rec_reg <= rec_next;

      if (open_win) begin
        win_cnt_reg   <= '0;
        winner_reg    <= '0;
        total_reg     <= '0;
        win_idx_reg   <= sample_idx_reg;
        win_epoch_reg <= epoch_reg;
      end else if (state_reg == ST_WINDOW) begin
        win_cnt_reg <= win_cnt_reg + 1'b1;
        winner_reg  <= winner_next;
        total_reg   <= total_next;
      end

      if (open_win) gap_reg <= '0;
      else if (state_reg == ST_IDLE && gap_reg != GAP_MAX) gap_reg <= gap_reg + 1'b1;

      // An epoch boundary wins over the index step of a window opening in the same cycle.
      if (eoe_rise || gap_boundary) begin
        sample_idx_reg <= '0;
        epoch_reg      <= epoch_reg + 1'b1;
      end else if (open_win) begin
        sample_idx_reg <= sample_idx_reg + 1'b1;
      end

      if (open_win) seen_sample_reg <= 1'b1;
      else if (eoe_rise || gap_boundary) seen_sample_reg <= 1'b0;

      if (push_reg && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  spike_result_fifo #(
    .p_width ($bits(result_t)),
    .p_depth (p_fifo_depth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_reg),
    .i_data  (rec_reg),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_valid        = !fifo_empty;
  assign pop            = o_valid && i_ready;
  assign o_winner       = head.winner;
  assign o_win_count    = head.win_count;
  assign o_total_count  = head.total_count;
  assign o_sample_index = head.sample_index;
  assign o_epoch        = head.epoch;
  assign o_epoch_done   = epoch_done_reg;
  assign o_overflow     = overflow_reg;

endmodule

// File: tb/tb_spike_response_monitor.sv
// Bench for spike_response_monitor: table-driven single samples, hand-written
// multi-cycle sequences, and a randomized run scored against a trace-level model.
module tb_spike_response_monitor;
  import snn_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [42:1] tv = '0;
  logic [8:1]  spk = '0;
  logic        eoe = 1'b0;
  logic        ready = 1'b0;
  logic        valid, epoch_done, overflow;
  logic [3:0]  winner;
  logic [3:0]  win_count;
  logic [6:0]  total_count;
  logic [15:0] sample_index;
  logic [7:0]  epoch;

  spike_response_monitor dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_test_vector  (tv),
    .i_spikes       (spk),
    .i_end_of_epochs(eoe),
    .i_ready        (ready),
    .o_valid        (valid),
    .o_winner       (winner),
    .o_win_count    (win_count),
    .o_total_count  (total_count),
    .o_sample_index (sample_index),
    .o_epoch        (epoch),
    .o_epoch_done   (epoch_done),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int winner;
    int win_count;
    int total;
    int idx;
    int epoch;
  } rec_t;

  typedef struct {
    logic [6:0][7:0] pat;
    int winner;
    int win_count;
    int total;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t dut_q[$];

  // Records are captured on the cycle they are handed to the consumer.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      rec_t r;
      r.winner    = int'(winner);
      r.win_count = int'(win_count);
      r.total     = int'(total_count);
      r.idx       = int'(sample_index);
      r.epoch     = int'(epoch);
      dut_q.push_back(r);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(input int w, input int c, input int t, input int i, input int e);
    rec_t r;
    r.winner = w; r.win_count = c; r.total = t; r.idx = i; r.epoch = e;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic p, input logic [7:0] s, input int n = 1);
    for (int k = 0; k < n; k++) begin
      tv  = (p && k == 0) ? 42'h1 : 42'h0;
      spk = (k == 0) ? s : 8'h00;
      tick();
    end
  endtask

  task automatic cmp_rec(input string name, input rec_t a, input rec_t e);
    $display("%s: winner=%0d wc=%0d total=%0d idx=%0d epoch=%0d (want %0d %0d %0d %0d %0d)",
             name, a.winner, a.win_count, a.total, a.idx, a.epoch,
             e.winner, e.win_count, e.total, e.idx, e.epoch);
    chk({name, ".winner"}, a.winner, e.winner);
    chk({name, ".win_count"}, a.win_count, e.win_count);
    chk({name, ".total"}, a.total, e.total);
    chk({name, ".sample_index"}, a.idx, e.idx);
    chk({name, ".epoch"}, a.epoch, e.epoch);
  endtask

  task automatic expect_q(input string name, input rec_t e[$]);
    chk({name, ".count"}, dut_q.size(), e.size());
    for (int i = 0; i < e.size() && i < dut_q.size(); i++)
      cmp_rec($sformatf("%s[%0d]", name, i), dut_q[i], e[i]);
    dut_q.delete();
  endtask

  task automatic do_reset();
    tv = '0; spk = '0; eoe = 1'b0; ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", int'(valid), 0);
    chk("rst.overflow", int'(overflow), 0);
    chk("rst.epoch_done", int'(epoch_done), 0);
    chk("rst.winner", int'(winner), 0);
    chk("rst.sample_index", int'(sample_index), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    dut_q.delete();
  endtask

  vec_t tbl[6];
  rec_t exp_q[$];
  int   pulse_at[30];
  logic [7:0] spk_tr[4096];
  bit   is_pulse[4096];

  initial begin
    foreach (tbl[i]) tbl[i].pat = '0;
    tbl[0].pat[2] = 8'h04; tbl[0].pat[4] = 8'h04;
    tbl[0].winner = 3; tbl[0].win_count = 2; tbl[0].total = 2;
    tbl[1].pat[1] = 8'h12; tbl[1].pat[3] = 8'h10;
    tbl[1].winner = 2; tbl[1].win_count = 1; tbl[1].total = 3;
    tbl[2].winner = 0; tbl[2].win_count = 0; tbl[2].total = 0;
    tbl[3].pat[0] = 8'h01; tbl[3].pat[5] = 8'h80;
    tbl[3].winner = 8; tbl[3].win_count = 1; tbl[3].total = 1;
    for (int o = 1; o <= 5; o++) tbl[4].pat[o] = 8'hFF;
    tbl[4].winner = 1; tbl[4].win_count = 5; tbl[4].total = 40;
    tbl[5].pat[6] = 8'h08;
    tbl[5].winner = 0; tbl[5].win_count = 0; tbl[5].total = 0;

    do_reset();

    // Single-sample table: o_valid timing and the head record while ready is low.
    for (int i = 0; i < 6; i++) begin
      for (int off = 0; off <= 8; off++) begin
        if (off == 6) chk($sformatf("tbl%0d.valid_t6", i), int'(valid), 0);
        if (off == 7) begin
          chk($sformatf("tbl%0d.valid_t7", i), int'(valid), 1);
          cmp_rec($sformatf("tbl%0d", i),
                  mk(int'(winner), int'(win_count), int'(total_count), int'(sample_index), int'(epoch)),
                  mk(tbl[i].winner, tbl[i].win_count, tbl[i].total, i, 0));
        end
        tv    = (off == 0) ? 42'h1 : 42'h0;
        spk   = 8'h00;
        if (off < 7) spk = tbl[i].pat[off];
        ready = (off == 7);
        tick();
      end
      chk($sformatf("tbl%0d.valid_after_pop", i), int'(valid), 0);
    end
    dut_q.delete();

    // Leave a record buffered so the reset below must discard it.
    cyc(1'b1, 8'h01);
    cyc(1'b0, 8'h00, 8);
    chk("pre_rst.valid", int'(valid), 1);
    do_reset();
    chk("post_rst.valid", int'(valid), 0);

    // Three samples 6 cycles apart, a long idle gap, then one more sample.
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'h00);
      cyc(1'b0, 8'h00, 2);
      cyc(1'b0, 8'(1 << k));
      cyc(1'b0, 8'h00, 2);
    end
    cyc(1'b0, 8'h00, 60);
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00, 2);
    cyc(1'b0, 8'h08);
    cyc(1'b0, 8'h00, 10);
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(k + 1, 1, 1, k, 0));
    exp_q.push_back(mk(4, 1, 1, 0, 1));
    expect_q("gap", exp_q);

    // Consumer stalled: four records kept, the fifth and sixth dropped.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 8'h00);
      cyc(1'b0, 8'(1 << k));
      cyc(1'b0, 8'h00, 6);
      chk($sformatf("ovf.after%0d", k + 1), int'(overflow), (k >= 4) ? 1 : 0);
    end
    ready = 1'b1;
    cyc(1'b0, 8'h00, 10);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(k + 1, 1, 1, k, 0));
    expect_q("ovf", exp_q);

    // Early close, then an end-of-epochs rise during an open window.
    do_reset();
    ready = 1'b1;
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h20);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h40);
    cyc(1'b0, 8'h00, 8);
    chk("eoe.done_idle", int'(epoch_done), 0);
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00);
    eoe = 1'b1;
    cyc(1'b0, 8'h00);
    chk("eoe.done_pulse", int'(epoch_done), 1);
    cyc(1'b0, 8'h00);
    chk("eoe.done_one_cycle", int'(epoch_done), 0);
    cyc(1'b0, 8'h02);
    cyc(1'b0, 8'h00, 8);
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h80);
    cyc(1'b0, 8'h00, 8);
    eoe = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(1, 1, 2, 0, 0));
    exp_q.push_back(mk(7, 1, 1, 1, 0));
    exp_q.push_back(mk(2, 1, 1, 2, 0));
    exp_q.push_back(mk(8, 1, 1, 0, 1));
    expect_q("early", exp_q);

    // Randomized run scored against a model built from the cycle trace.
    do_reset();
    begin
      int last_c;
      int idx;
      int ep;
      pulse_at[0] = 2;
      for (int k = 1; k < 30; k++) begin
        int r;
        int s;
        r = $urandom_range(0, 9);
        if (r < 2)       s = $urandom_range(3, 5);
        else if (r == 2) s = 6;
        else if (r == 9) s = $urandom_range(57, 65);
        else             s = $urandom_range(7, 15);
        pulse_at[k] = pulse_at[k-1] + s;
      end
      last_c = pulse_at[29] + 12;
      for (int c = 0; c < 4096; c++) begin
        is_pulse[c] = 1'b0;
        spk_tr[c]   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      foreach (pulse_at[k]) is_pulse[pulse_at[k]] = 1'b1;

      exp_q.delete();
      idx = 0;
      ep  = 0;
      for (int k = 0; k < 30; k++) begin
        int cnt[8];
        int tot;
        int w;
        int wend;
        if (k > 0 && (pulse_at[k] - pulse_at[k-1] - 7) >= 50) begin
          ep++;
          idx = 0;
        end
        wend = pulse_at[k] + 5;
        if (k < 29 && pulse_at[k+1] < wend) wend = pulse_at[k+1];
        foreach (cnt[n]) cnt[n] = 0;
        tot = 0;
        w   = 0;
        for (int c = pulse_at[k] + 1; c <= wend; c++) begin
          for (int n = 0; n < 8; n++) begin
            if (spk_tr[c][n]) begin
              cnt[n]++;
              tot++;
              if (w == 0) w = n + 1;
            end
          end
        end
        exp_q.push_back(mk(w, (w == 0) ? 0 : cnt[w-1], tot, idx, ep));
        idx++;
      end

      ready = 1'b1;
      for (int c = 0; c < last_c; c++) begin
        logic [42:1] v;
        v = 42'({$urandom, $urandom});
        v[$urandom_range(1, 42)] = 1'b1;
        tv  = is_pulse[c] ? v : 42'h0;
        spk = spk_tr[c];
        if (!ready) ready = 1'b1;
        else        ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      tv = '0; spk = '0; ready = 1'b1;
      for (int c = 0; c < 40 && dut_q.size() < exp_q.size(); c++) tick();
      chk("rand.overflow", int'(overflow), 0);
      expect_q("rand", exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
